// File: rtl/preg_freelist.sv
// Circular free list of physical register IDs for the rename stage.
// Ports: clk/rstn (sync, active-low); alloc_req/alloc_gnt/alloc_preg (rename);
//   free_valid/free_preg (commit); rollback_valid/rollback_num (flush);
//   free_count/empty (occupancy); err (sticky protocol error).
module preg_freelist #(
    parameter int PRFSIZE      = 64,
    parameter int PREG_ID_BITS = $clog2(PRFSIZE)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    alloc_req,
    output logic                    alloc_gnt,
    output logic [PREG_ID_BITS-1:0] alloc_preg,
    input  logic                    free_valid,
    input  logic [PREG_ID_BITS-1:0] free_preg,
    input  logic                    rollback_valid,
    input  logic [PREG_ID_BITS:0]   rollback_num,
    output logic [PREG_ID_BITS:0]   free_count,
    output logic                    empty,
    output logic                    err
);

    localparam int PB = PREG_ID_BITS;
    localparam int CW = PB + 1;
    localparam logic [CW-1:0] FULL = CW'(PRFSIZE);

    logic [PB-1:0] fl_q [PRFSIZE];
    logic [PB-1:0] head_q, head_d;
    logic [PB-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;

    logic          cnt_zero;
    logic          cnt_full;
    logic          bypass;
    logic          do_alloc;
    logic          free_acc;
    logic          free_ovf;
    logic [CW:0]   rb_sum;
    logic          rb_bad;
    logic          rb_ok;

    assign cnt_zero = (count_q == '0);
    assign cnt_full = (count_q == FULL);

    // Grant is zero-latency; an empty list can still grant by forwarding
    // the preg that commit is releasing this same cycle.
    assign alloc_gnt  = alloc_req && !rollback_valid
                        && (!cnt_zero || free_valid);
    assign alloc_preg = cnt_zero ? free_preg : fl_q[head_q];

    assign bypass   = alloc_gnt && cnt_zero;
    assign do_alloc = alloc_gnt && !cnt_zero;
    assign free_acc = free_valid && !cnt_full && !bypass;
    assign free_ovf = free_valid && cnt_full;

    // One extra bit so an oversized rollback cannot wrap and look legal.
    assign rb_sum = {1'b0, count_q}
                  + {1'b0, rollback_num}
                  + {{CW{1'b0}}, free_acc};
    assign rb_bad = rollback_valid && (rb_sum > {1'b0, FULL});
    assign rb_ok  = rollback_valid && !rb_bad;

    always_comb begin
        head_d = head_q;
        if (do_alloc) begin
            head_d = head_q + PB'(1);
        end else if (rb_ok) begin
            // Rolled-back IDs still sit just behind head; step back over them.
            head_d = head_q - rollback_num[PB-1:0];
        end
    end

    always_comb begin
        tail_d = tail_q;
        if (free_acc) begin
            tail_d = tail_q + PB'(1);
        end
    end

    always_comb begin
        count_d = count_q;
        if (rb_ok) begin
            count_d = rb_sum[CW-1:0];
        end else begin
            count_d = count_q + CW'(free_acc) - CW'(do_alloc);
        end
    end

    always_comb begin
        err_d = err_q | free_ovf | rb_bad;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= FULL;
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < PRFSIZE; i++) begin
                fl_q[i] <= PB'(i);
            end
        end else if (free_acc) begin
            fl_q[tail_q] <= free_preg;
        end
    end

    assign free_count = count_q;
    assign empty      = cnt_zero;
    assign err        = err_q;

endmodule

// File: tb/tb_preg_freelist.sv
// Self-checking bench for preg_freelist.
// Directed scenarios plus a randomized run against a queue-based model.
module tb_preg_freelist;

    localparam int N = 64;

    logic       clk = 1'b0;
    logic       rstn;
    logic       alloc_req;
    logic       alloc_gnt;
    logic [5:0] alloc_preg;
    logic       free_valid;
    logic [5:0] free_preg;
    logic       rollback_valid;
    logic [6:0] rollback_num;
    logic [6:0] free_count;
    logic       empty;
    logic       err;

    int checks = 0;
    int errors = 0;

    // Model: q = IDs available, front first.  hist = IDs handed out from
    // the list (oldest first) that a rollback may still return; the list
    // plus its recyclable history always cover all N slots.
    int q[$];
    int hist[$];
    bit merr;

    preg_freelist #(.PRFSIZE(N)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .alloc_req      (alloc_req),
        .alloc_gnt      (alloc_gnt),
        .alloc_preg     (alloc_preg),
        .free_valid     (free_valid),
        .free_preg      (free_preg),
        .rollback_valid (rollback_valid),
        .rollback_num   (rollback_num),
        .free_count     (free_count),
        .empty          (empty),
        .err            (err)
    );

    always #5 clk = ~clk;

    task automatic mdl_step();
        int cnt;
        bit gnt;
        bit facc;
        bit rbok;
        int v;
        if (!rstn) begin
            q.delete();
            hist.delete();
            for (int i = 0; i < N; i++) q.push_back(i);
            merr = 1'b0;
            return;
        end
        cnt = q.size();
        gnt = alloc_req && !rollback_valid && (cnt != 0 || free_valid);
        if (gnt && cnt == 0) return;
        facc = free_valid && cnt < N;
        if (free_valid && cnt == N) merr = 1'b1;
        rbok = 1'b0;
        if (rollback_valid) begin
            if (cnt + int'(rollback_num) + int'(facc) > N) merr = 1'b1;
            else rbok = 1'b1;
        end
        if (facc) void'(hist.pop_front());
        if (gnt) begin
            v = q.pop_front();
            hist.push_back(v);
        end
        if (rbok) begin
            for (int k = 0; k < int'(rollback_num); k++) begin
                v = hist.pop_back();
                q.push_front(v);
            end
        end
        if (facc) q.push_back(int'(free_preg));
    endtask

    task automatic set_in(input bit ar, input bit fv, input int fp,
                          input bit rv, input int rn);
        @(negedge clk);
        alloc_req      = ar;
        free_valid     = fv;
        free_preg      = 6'(fp);
        rollback_valid = rv;
        rollback_num   = 7'(rn);
        #1;
    endtask

    task automatic tick();
        mdl_step();
        @(posedge clk);
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0);
        rstn = 1'b0;
        tick();
        tick();
        set_in(0, 0, 0, 0, 0);
        rstn = 1'b1;
        tick();
    endtask

    task automatic alloc_n(input int n, input int first);
        for (int i = 0; i < n; i++) begin
            set_in(1, 0, 0, 0, 0);
            checks++;
            if (alloc_gnt !== 1'b1 || alloc_preg !== 6'(first + i)) begin
                errors++;
                $display("FAIL alloc_seq[%0d] gnt=%0b preg=%0d want gnt=1 preg=%0d",
                         i, alloc_gnt, alloc_preg, first + i);
            end
            tick();
        end
    endtask

    task automatic test_reset();
        do_reset();
        set_in(0, 0, 0, 0, 0);
        checks++;
        if (free_count !== 7'd64 || empty !== 1'b0 ||
            alloc_gnt !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset cnt=%0d empty=%0b gnt=%0b err=%0b want 64 0 0 0",
                     free_count, empty, alloc_gnt, err);
        end
    endtask

    task automatic test_alloc_all();
        do_reset();
        alloc_n(N, 0);
        set_in(0, 0, 0, 0, 0);
        checks++;
        if (free_count !== 7'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL drained cnt=%0d empty=%0b want 0 1", free_count, empty);
        end
        set_in(1, 0, 0, 0, 0);
        checks++;
        if (alloc_gnt !== 1'b0) begin
            errors++;
            $display("FAIL alloc_when_empty gnt=%0b want 0", alloc_gnt);
        end
        tick();
    endtask

    task automatic test_bypass();
        set_in(1, 1, 17, 0, 0);
        checks++;
        if (alloc_gnt !== 1'b1 || alloc_preg !== 6'd17) begin
            errors++;
            $display("FAIL bypass gnt=%0b preg=%0d want 1 17", alloc_gnt, alloc_preg);
        end
        tick();
        set_in(0, 0, 0, 0, 0);
        checks++;
        if (free_count !== 7'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL bypass_cnt cnt=%0d empty=%0b want 0 1", free_count, empty);
        end
    endtask

    task automatic test_rollback();
        do_reset();
        alloc_n(10, 0);
        set_in(1, 0, 0, 1, 4);
        checks++;
        if (alloc_gnt !== 1'b0) begin
            errors++;
            $display("FAIL rollback_gnt gnt=%0b want 0", alloc_gnt);
        end
        tick();
        set_in(0, 0, 0, 0, 0);
        checks++;
        if (free_count !== 7'd58) begin
            errors++;
            $display("FAIL rollback_cnt cnt=%0d want 58", free_count);
        end
        alloc_n(4, 6);
        set_in(1, 0, 0, 1, 0);
        checks++;
        if (alloc_gnt !== 1'b0) begin
            errors++;
            $display("FAIL rollback0_gnt gnt=%0b want 0", alloc_gnt);
        end
        tick();
        set_in(0, 0, 0, 0, 0);
        checks++;
        if (free_count !== 7'd54 || err !== 1'b0) begin
            errors++;
            $display("FAIL rollback0_cnt cnt=%0d err=%0b want 54 0", free_count, err);
        end
    endtask

    task automatic test_simul();
        do_reset();
        alloc_n(59, 0);
        set_in(1, 1, 40, 0, 0);
        checks++;
        if (alloc_gnt !== 1'b1 || alloc_preg !== 6'd59) begin
            errors++;
            $display("FAIL simul_gnt gnt=%0b preg=%0d want 1 59", alloc_gnt, alloc_preg);
        end
        tick();
        set_in(0, 0, 0, 0, 0);
        checks++;
        if (free_count !== 7'd5) begin
            errors++;
            $display("FAIL simul_cnt cnt=%0d want 5", free_count);
        end
        alloc_n(4, 60);
        set_in(1, 0, 0, 0, 0);
        checks++;
        if (alloc_gnt !== 1'b1 || alloc_preg !== 6'd40) begin
            errors++;
            $display("FAIL simul_wrap gnt=%0b preg=%0d want 1 40", alloc_gnt, alloc_preg);
        end
        tick();
    endtask

    task automatic test_overflow();
        do_reset();
        set_in(0, 1, 3, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0);
        checks++;
        if (err !== 1'b1 || free_count !== 7'd64) begin
            errors++;
            $display("FAIL overflow err=%0b cnt=%0d want 1 64", err, free_count);
        end
        alloc_n(2, 0);
        set_in(0, 1, 9, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0);
        checks++;
        if (err !== 1'b1 || free_count !== 7'd63) begin
            errors++;
            $display("FAIL err_sticky err=%0b cnt=%0d want 1 63", err, free_count);
        end
        set_in(0, 0, 0, 1, 5);
        tick();
        set_in(0, 0, 0, 0, 0);
        checks++;
        if (free_count !== 7'd63) begin
            errors++;
            $display("FAIL bad_rollback cnt=%0d want 63", free_count);
        end
        do_reset();
        set_in(0, 0, 0, 0, 0);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear err=%0b want 0", err);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        alloc_n(44, 0);
        set_in(1, 1, 5, 0, 0);
        rstn = 1'b0;
        tick();
        set_in(0, 0, 0, 0, 0);
        rstn = 1'b1;
        checks++;
        if (free_count !== 7'd64 || err !== 1'b0 || empty !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid cnt=%0d err=%0b empty=%0b want 64 0 0",
                     free_count, err, empty);
        end
        tick();
        alloc_n(1, 0);
    endtask

    task automatic test_random();
        int bias;
        int ecnt;
        bit egnt;
        int epreg;
        bit ar, fv, rv;
        int rn;
        do_reset();
        bias = 2;
        for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) bias = $urandom_range(0, 4);
            ar = ($urandom_range(0, 4) < bias);
            fv = ($urandom_range(0, 4) >= bias);
            rv = ($urandom_range(0, 11) == 0);
            rn = $urandom_range(0, hist.size() + 2);
            set_in(ar, fv, $urandom_range(0, N - 1), rv, rn);
            rstn = ($urandom_range(0, 399) != 0);
            ecnt  = q.size();
            egnt  = ar && !rv && (ecnt != 0 || fv);
            epreg = (ecnt != 0) ? q[0] : int'(free_preg);
            checks++;
            if (alloc_gnt !== egnt || (egnt && alloc_preg !== 6'(epreg))) begin
                errors++;
                $display("FAIL rnd_gnt c=%0d gnt=%0b preg=%0d want %0b %0d",
                         c, alloc_gnt, alloc_preg, egnt, epreg);
            end
            checks++;
            if (free_count !== 7'(ecnt) || empty !== (ecnt == 0) ||
                err !== merr) begin
                errors++;
                $display("FAIL rnd_state c=%0d cnt=%0d empty=%0b err=%0b want %0d %0b %0b",
                         c, free_count, empty, err, ecnt, ecnt == 0, merr);
            end
            tick();
        end
        set_in(0, 0, 0, 0, 0);
        rstn = 1'b1;
    endtask

    initial begin
        rstn           = 1'b0;
        alloc_req      = 1'b0;
        free_valid     = 1'b0;
        free_preg      = '0;
        rollback_valid = 1'b0;
        rollback_num   = '0;
        test_reset();
        test_alloc_all();
        test_bypass();
        test_rollback();
        test_simul();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
